// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider: operands in, status and result out.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output busy, done, result
  );
endinterface

// File: rtl/seq_divider.sv
// RV32M DIV/DIVU/REM/REMU by restoring division, one quotient bit per cycle,
// with single-cycle bypass for divide-by-zero and signed overflow.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rem_sel;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             is_signed_c;
  logic             div_zero_c;
  logic             ovf_c;
  logic [WIDTH-1:0] dvd_abs_c;
  logic [WIDTH-1:0] dvs_abs_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  // Operand classification, one restoring step, and final sign fix-up
  always_comb begin
    is_signed_c = ~bus.op[0];
    div_zero_c  = (bus.divisor == '0);
    ovf_c       = is_signed_c && (bus.dividend == INT_MIN) && (bus.divisor == ALL_ONES);
    dvd_abs_c   = (is_signed_c && bus.dividend[WIDTH-1]) ? WIDTH'(-bus.dividend) : bus.dividend;
    dvs_abs_c   = (is_signed_c && bus.divisor[WIDTH-1])  ? WIDTH'(-bus.divisor)  : bus.divisor;
    shifted_c   = {rem, quo[WIDTH-1]};
    diff_c      = shifted_c - {1'b0, dvs};
    quo_fix_c   = q_neg ? WIDTH'(-quo) : quo;
    rem_fix_c   = r_neg ? WIDTH'(-rem) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_sel  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem_sel <= bus.op[1];
            cnt     <= '0;
            busy_q  <= 1'b1;
            // Special cases preload the final answer and skip straight to FIX
            if (div_zero_c) begin
              quo   <= ALL_ONES;
              rem   <= bus.dividend;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              state <= FIX;
            end else if (ovf_c) begin
              quo   <= INT_MIN;
              rem   <= '0;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              state <= FIX;
            end else begin
              quo   <= dvd_abs_c;
              rem   <= '0;
              dvs   <= dvs_abs_c;
              q_neg <= is_signed_c & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              r_neg <= is_signed_c & bus.dividend[WIDTH-1];
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!diff_c[WIDTH]) begin
            rem <= diff_c[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted_c[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result_q <= rem_sel ? rem_fix_c : quo_fix_c;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand-written multi-cycle sequences.
module tb_seq_divider;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[18];

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request for exactly one edge (E0), then scramble the operand inputs
  task automatic apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.op       = 2'($urandom());
    bus.dividend = $urandom();
    bus.divisor  = $urandom();
  endtask

  // Count edges after E0 until done is seen; bounded so a missing done cannot hang
  task automatic wait_done(input int start_n, output int n);
    n = start_n;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) return;
    end
  endtask

  initial begin
    int   n;
    logic seen;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,        33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,        32'd2,         33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 33};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE, 32'd1,        33};
    vecs[5]  = '{OP_DIVU, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 1};
    vecs[6]  = '{OP_REMU, 32'h0000_1234,  32'd0,        32'h0000_1234, 1};
    vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        1};
    vecs[9]  = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       33};
    vecs[10] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 33};
    vecs[11] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 33};
    vecs[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        33};
    vecs[13] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[14] = '{OP_DIV,  32'h8000_0000,  32'd1,        32'h8000_0000, 33};
    vecs[15] = '{OP_DIV,  32'd7,          32'd0,        32'hFFFF_FFFF, 1};
    vecs[16] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9, 1};
    vecs[17] = '{OP_DIV,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   32'(bus.busy), 32'd0);
    check("reset done",   32'(bus.done), 32'd0);
    check("reset result", bus.result,    32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'd1);
      wait_done(0, n);
      check($sformatf("vec%0d latency", i), 32'(n), 32'(vecs[i].lat));
      check($sformatf("vec%0d result", i), bus.result, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done drop", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d hold", i), bus.result, vecs[i].exp);
    end

    // A second start at E5 must not disturb the run in flight
    apply(OP_DIVU, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b1;
    bus.op       = OP_DIVU;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(5, n);
    check("mid start latency", 32'(n), 32'd33);
    check("mid start result",  bus.result, 32'd14);
    @(posedge clk);
    #1;
    check("mid start no restart", 32'(bus.busy), 32'd0);

    // Back-to-back: new request issued in the done cycle
    apply(OP_DIVU, 32'd100, 32'd7);
    wait_done(0, n);
    check("b2b first latency", 32'(n), 32'd33);
    check("b2b first result",  bus.result, 32'd14);
    apply(OP_REMU, 32'd100, 32'd7);
    check("b2b second busy", 32'(bus.busy), 32'd1);
    check("b2b done drop",   32'(bus.done), 32'd0);
    wait_done(0, n);
    check("b2b second latency", 32'(n), 32'd33);
    check("b2b second result",  bus.result, 32'd2);

    // Reset at E10 aborts the run; a start alongside rst is ignored
    apply(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.op       = OP_DIVU;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("abort busy",   32'(bus.busy), 32'd0);
    check("abort done",   32'(bus.done), 32'd0);
    check("abort result", bus.result,    32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort idle result", bus.result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have clk  input  1  rising-edge clock; the block uses one clock.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-006 SHALL have dividend  input  32  operand rs1; sampled with start.
REQ-007 SHALL have divisor  input  32  operand rs2; sampled with start.
REQ-008 SHALL have busy  output  1  high while an operation is in flight.
REQ-009 SHALL have done  output  1  one-cycle completion pulse.
REQ-010 SHALL have result  output  32  quotient or remainder; holds until the next completion.

Function
REQ-011 SHALL implement states IDLE, RUN and FIX.
- IDLE with start=1 at edge E0 -> RUN.
- RUN runs 32 iterations at edges E1..E32; E32 -> FIX.
- FIX at E33 -> IDLE.
REQ-012 SHALL register op, operand magnitudes, quotient sign and remainder sign at E0.
- Magnitudes are two's-complement absolute values for op 00/10; raw operands for op 01/11.
REQ-013 SHALL perform one restoring iteration per RUN cycle.
- Shift the {remainder, quotient} pair left by 1.
- Perform a 33-bit trial subtraction of the divisor.
- If the difference is non-negative, keep it and set the quotient LSB to 1.
- Otherwise restore the remainder and set the quotient LSB to 0.
REQ-014 SHALL apply sign fix-up and select the output at E33.
- Negate the quotient if the operand signs differ (signed ops only).
- Give the remainder the sign of the dividend (signed ops only).
- Load result, and set done=1 for the cycle E33..E34.
REQ-015 SHALL give busy=1 from E0 until E33, i.e. in RUN and FIX, with a latency of 33 cycles from the start sample to the done cycle.
REQ-016 SHALL handle divisor==0 at E0 by bypassing RUN.
- Result loaded at E1 with done=1 for one cycle.
- Result is 0xFFFFFFFF for DIV/DIVU, and the dividend for REM/REMU.
REQ-017 SHALL handle signed overflow (op 00/10, dividend 0x80000000, divisor 0xFFFFFFFF) by bypassing RUN.
- DIV result is 0x80000000 and REM result is 0, loaded at E1 with done=1.
REQ-018 SHALL ignore start while busy=1; operand inputs SHALL not affect an operation in flight.
REQ-019 SHALL accept start in the same cycle that done=1, because the FSM is already in IDLE.
REQ-020 SHALL keep result stable, and done=0, in IDLE when no completion occurs.

Reset
REQ-021 SHALL on rst=1 at an edge force IDLE, busy=0, done=0, result=0 and clear the iteration counter.
REQ-022 SHALL on rst mid-operation abort the operation with no done pulse; start SHALL be ignored in any cycle with rst=1.

Verification
REQ-023 DIVU 100/7: start at E0 -> done at E33 with result 14; REMU with the same operands -> 2.
REQ-024 DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-025 DIVU x/0 with x=0x1234 -> done at E1, result 0xFFFFFFFF; REMU x/0 -> 0x1234.
REQ-026 DIV 0x80000000/0xFFFFFFFF -> done at E1, result 0x80000000; REM -> 0.
REQ-027 Start pulsed at E5 during a run -> ignored, same result; back-to-back start in the done cycle -> second done 33 cycles later.
REQ-028 rst asserted at E10 of a run -> busy=0, done=0, result=0 next cycle, and no done ever appears for the aborted op.
